// File: rtl/next_state.sv
// Transition unit of the 8-state, 5-symbol Turing machine controller, plus a
// registered copy of the machine state. Optional checking macro: NEXT_STATE_ILLEGAL_CHECK_EN.
module next_state (
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  input  logic [7:0] state_in,
  input  logic       s2,
  input  logic       s1,
  input  logic       s0,
  output logic [7:0] state_out,
  output logic [7:0] state_q,
  output logic       err
);

  localparam logic [7:0] STATE_A = 8'h01;

  logic [2:0] sym;
  logic [7:0] rot;
  logic       sym_illegal;
  logic [7:0] state_d;

  assign sym = {s2, s1, s0};

  always_comb begin
    rot         = state_in;
    sym_illegal = 1'b0;
    case (sym)
      3'b000:  rot = state_in;
      3'b001:  rot = {state_in[6:0], state_in[7]};
      3'b010:  rot = {state_in[0], state_in[7:1]};
      3'b100:  rot = {state_in[5:0], state_in[7:6]};
      3'b101:  rot = {state_in[3:0], state_in[7:4]};
      default: begin
        rot         = state_in;
        sym_illegal = 1'b1;
      end
    endcase
  end

`ifdef NEXT_STATE_ILLEGAL_CHECK_EN
  logic one_hot;

  // x & (x-1) clears the lowest set bit, so it is zero only for zero or one-hot x.
  always_comb begin
    one_hot   = (state_in != 8'h00) && ((state_in & (state_in - 8'd1)) == 8'h00);
    err       = sym_illegal || !one_hot;
    state_out = err ? 8'h00 : rot;
  end
`else
  always_comb begin
    err       = 1'b0;
    state_out = rot;
  end
`endif

  always_comb begin
    state_d = state_q;
    if (rst) begin
      state_d = STATE_A;
    end else if (step && !err) begin
      state_d = state_out;
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
  end

endmodule

// File: tb/tb_next_state.sv
// Directed self-checking bench for next_state; expectations follow the
// NEXT_STATE_ILLEGAL_CHECK_EN setting of the build.
module tb_next_state;

  logic       clk;
  logic       rst;
  logic       step;
  logic [7:0] state_in;
  logic       s2, s1, s0;
  logic [7:0] state_out;
  logic [7:0] state_q;
  logic       err;

  int checks = 0;
  int passes = 0;

  next_state dut (
    .clk       (clk),
    .rst       (rst),
    .step      (step),
    .state_in  (state_in),
    .s2        (s2),
    .s1        (s1),
    .s0        (s0),
    .state_out (state_out),
    .state_q   (state_q),
    .err       (err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver
  task automatic drive(input logic [7:0] st, input logic [2:0] sy, input logic stp, input logic rs);
    state_in = st;
    {s2, s1, s0} = sy;
    step = stp;
    rst = rs;
  endtask

  // scoreboard helpers
  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  logic [2:0] codes [5];
  int         offs  [5];
  logic [7:0] one;
  logic [7:0] q_before;

  initial begin
    codes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    offs  = '{0, 1, 7, 2, 4};
    one   = 8'h01;

    // reset
    drive(8'h00, 3'b000, 1'b0, 1'b1);
    @(posedge clk); #1;
    check8("reset_state_q", state_q, 8'h01);
    @(negedge clk);
    drive(8'h00, 3'b000, 1'b0, 1'b0);

    // one-hot sweep over legal symbols: next index is (i + offset) mod 8
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 5; k++) begin
        drive(one << i, codes[k], 1'b0, 1'b0);
        #1;
        check8($sformatf("sweep_i%0d_sym%b", i, codes[k]), state_out, one << ((i + offs[k]) % 8));
        check1($sformatf("sweep_err_i%0d_sym%b", i, codes[k]), err, 1'b0);
      end
    end

    // spot checks written out by hand
    drive(8'h04, 3'b001, 1'b0, 1'b0); #1; check8("c_next_d", state_out, 8'h08);
    drive(8'h01, 3'b010, 1'b0, 1'b0); #1; check8("a_prev_h", state_out, 8'h80);
    drive(8'h80, 3'b100, 1'b0, 1'b0); #1; check8("h_skip_b", state_out, 8'h02);
    drive(8'h02, 3'b101, 1'b0, 1'b0); #1; check8("b_opp_f", state_out, 8'h20);

    // illegal symbols
    for (int k = 0; k < 3; k++) begin
      logic [2:0] bad;
      bad = (k == 0) ? 3'b011 : (k == 1) ? 3'b110 : 3'b111;
      drive(8'h10, bad, 1'b0, 1'b0); #1;
`ifdef NEXT_STATE_ILLEGAL_CHECK_EN
      check8($sformatf("illegal_out_%b", bad), state_out, 8'h00);
      check1($sformatf("illegal_err_%b", bad), err, 1'b1);
`else
      check8($sformatf("illegal_out_%b", bad), state_out, 8'h10);
      check1($sformatf("illegal_err_%b", bad), err, 1'b0);
`endif
    end

    // multi-hot and zero states
    drive(8'h03, 3'b001, 1'b0, 1'b0); #1;
`ifdef NEXT_STATE_ILLEGAL_CHECK_EN
    check8("multihot_out", state_out, 8'h00);
    check1("multihot_err", err, 1'b1);
`else
    check8("multihot_out", state_out, 8'h06);
    check1("multihot_err", err, 1'b0);
`endif
    drive(8'h81, 3'b101, 1'b0, 1'b0); #1;
`ifdef NEXT_STATE_ILLEGAL_CHECK_EN
    check8("multihot_wrap_out", state_out, 8'h00);
`else
    check8("multihot_wrap_out", state_out, 8'h18);
`endif
    drive(8'h00, 3'b001, 1'b0, 1'b0); #1;
    check8("zero_out", state_out, 8'h00);
`ifdef NEXT_STATE_ILLEGAL_CHECK_EN
    check1("zero_err", err, 1'b1);
`else
    check1("zero_err", err, 1'b0);
`endif

    // state_q after the combinational sweep must still be A
    check8("q_untouched_by_sweep", state_q, 8'h01);

    // step A with sym 100 -> C
    @(negedge clk);
    drive(8'h01, 3'b100, 1'b1, 1'b0);
    @(posedge clk); #1;
    check8("step_a_to_c", state_q, 8'h04);
    @(negedge clk);
    drive(8'h20, 3'b001, 1'b0, 1'b0);
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      check8($sformatf("hold_edge%0d", n), state_q, 8'h04);
    end

    // second step from a different state_in: F with sym 001 -> G
    @(negedge clk);
    drive(8'h20, 3'b001, 1'b1, 1'b0);
    @(posedge clk); #1;
    check8("step_f_to_g", state_q, 8'h40);

    // rst and step together: reset wins; state_out ignores rst
    @(negedge clk);
    drive(8'h08, 3'b001, 1'b1, 1'b1);
    #1;
    check8("out_during_rst", state_out, 8'h10);
    @(posedge clk); #1;
    check8("rst_over_step", state_q, 8'h01);

    // step with an illegal symbol
    @(negedge clk);
    drive(8'h10, 3'b111, 1'b1, 1'b0);
    q_before = 8'h01;
    @(posedge clk); #1;
`ifdef NEXT_STATE_ILLEGAL_CHECK_EN
    check8("illegal_step_holds", state_q, q_before);
`else
    check8("illegal_step_loads", state_q, 8'h10);
`endif

    @(negedge clk);
    drive(8'h00, 3'b000, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
